// File: rtl/md_iter_core_pkg.sv
// Shared encodings for the iterative multiply/divide core: operation codes,
// FSM state codes and the iteration count.
package md_iter_core_pkg;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int          STEPS    = 32;
    localparam logic [4:0]  LAST_STEP = 5'(STEPS - 1);

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Sign handling for md_iter_core: operand magnitudes on the way in and
// result sign correction (product negate, truncating quotient/remainder) on the way out.
module md_sign_fix
    import md_iter_core_pkg::*;
(
    input  logic        sign,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    output logic [31:0] mag0,
    output logic [31:0] mag1,
    output logic        neg0,
    output logic        neg1,
    input  logic        fix_div,
    input  logic        fix_neg0,
    input  logic        fix_neg1,
    input  logic        fix_dz,
    input  logic [63:0] raw,
    output logic [63:0] fixed
);

    logic [31:0] quo;
    logic [31:0] rem;

    assign neg0 = sign & src0[31];
    assign neg1 = sign & src1[31];
    assign mag0 = neg0 ? neg32(src0) : src0;
    assign mag1 = neg1 ? neg32(src1) : src1;

    // Divide-by-zero forces an all-ones quotient regardless of operand signs;
    // the remainder magnitude is |dividend|, so re-applying its sign restores it.
    always_comb begin
        quo   = raw[31:0];
        rem   = raw[63:32];
        fixed = raw;
        if (fix_div) begin
            if (fix_dz)
                quo = 32'hFFFF_FFFF;
            else if (fix_neg0 ^ fix_neg1)
                quo = neg32(raw[31:0]);
            if (fix_neg0)
                rem = neg32(raw[63:32]);
            fixed = {rem, quo};
        end else if (fix_neg0 ^ fix_neg1) begin
            fixed = ~raw + 64'd1;
        end
    end

endmodule

// File: rtl/md_iter_core.sv
// Radix-2 iterative 32x32 multiply / 32/32 divide core with valid/ready handshakes.
// Optional macro MD_FAST_MUL_EN: single-cycle registered multiply for MUL.
module md_iter_core
    import md_iter_core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_src0,
    input  logic [31:0] in_src1,
    input  logic [1:0]  in_op,
    input  logic        in_sign,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res0,
    output logic [31:0] out_res1
);

    // state   | meaning
    // IDLE    | waiting for a MUL/DIV request, in_ready high
    // BUSY    | one shift-add / restoring-subtract step per cycle
    // FIX     | phase 0: register sign-corrected result; phase 1: publish it
    // DONE    | out_valid high until out_ready

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        fix_phase;
    logic        op_div;
    logic        neg0_r;
    logic        neg1_r;
    logic        dz_r;
    logic [31:0] opnd_r;
    logic [63:0] work;
    logic [31:0] res0_r;
    logic [31:0] res1_r;

    logic [31:0] mag0;
    logic [31:0] mag1;
    logic        neg0;
    logic        neg1;
    logic [63:0] fixed;
    logic        req_ok;
    logic        req_div;

    logic [32:0] add_sum;
    logic [33:0] sub_trial;
    logic [63:0] step_next;
    logic        step_last;

    md_sign_fix u_sign_fix (
        .sign     (in_sign),
        .src0     (in_src0),
        .src1     (in_src1),
        .mag0     (mag0),
        .mag1     (mag1),
        .neg0     (neg0),
        .neg1     (neg1),
        .fix_div  (op_div),
        .fix_neg0 (neg0_r),
        .fix_neg1 (neg1_r),
        .fix_dz   (dz_r),
        .raw      (work),
        .fixed    (fixed)
    );

    assign req_div = (in_op == OP_DIV);
    assign req_ok  = in_valid && ((in_op == OP_MUL) || req_div);

    // work holds {partial_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV;
    // opnd_r is the multiplicand or the divisor magnitude.
    always_comb begin
        add_sum   = {1'b0, work[63:32]} + {1'b0, opnd_r};
        sub_trial = {1'b0, work[63:31]} - {2'b00, opnd_r};
        step_last = (cnt == LAST_STEP);
        if (op_div)
            step_next = sub_trial[33] ? {work[62:0], 1'b0}
                                      : {sub_trial[31:0], work[30:0], 1'b1};
        else
            step_next = work[0] ? {add_sum, work[31:1]} : {1'b0, work[63:1]};
`ifdef MD_FAST_MUL_EN
        if (!op_div) begin
            step_next = {32'd0, opnd_r} * {32'd0, work[31:0]};
            step_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            fix_phase <= 1'b0;
            op_div    <= 1'b0;
            neg0_r    <= 1'b0;
            neg1_r    <= 1'b0;
            dz_r      <= 1'b0;
            opnd_r    <= '0;
            work      <= '0;
            res0_r    <= '0;
            res1_r    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        op_div <= req_div;
                        neg0_r <= neg0;
                        neg1_r <= neg1;
                        dz_r   <= req_div && (in_src1 == 32'd0);
                        opnd_r <= req_div ? mag1 : mag0;
                        work   <= {32'd0, req_div ? mag0 : mag1};
                        cnt    <= '0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work <= step_next;
                    if (step_last) begin
                        cnt       <= '0;
                        fix_phase <= 1'b0;
                        state     <= ST_FIX;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_FIX: begin
                    if (!fix_phase) begin
                        work      <= fixed;
                        fix_phase <= 1'b1;
                    end else begin
                        res0_r    <= work[31:0];
                        res1_r    <= work[63:32];
                        fix_phase <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_res0  = res0_r;
    assign out_res1  = res1_r;

endmodule

// File: tb/tb_md_iter_core.sv
// Randomized self-checking bench for md_iter_core against an arithmetic reference model.
// Honors MD_FAST_MUL_EN for the expected MUL latency.
module tb_md_iter_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_src0;
    logic [31:0] in_src1;
    logic [1:0]  in_op;
    logic        in_sign;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res0;
    logic [31:0] out_res1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_res = 64'd0;

    md_iter_core dut (
        .clk       (clk),
        .reset     (reset),
        .in_src0   (in_src0),
        .in_src1   (in_src1),
        .in_op     (in_op),
        .in_sign   (in_sign),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res0  (out_res0),
        .out_res1  (out_res1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {res1,res0} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic s);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] res;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        ua = longint'(a);
        ub = longint'(b);
        if (op == 2'd1) begin
            if (s) res = sa * sb;
            else   res = ua * ub;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    function automatic int exp_latency(input logic [1:0] op);
`ifdef MD_FAST_MUL_EN
        if (op == 2'd1) return 3;
`endif
        return 34;
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom);
        in_src0  = $urandom;
        in_src1  = $urandom;
        in_op    = 2'($urandom);
        in_sign  = 1'($urandom);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic s, input int hold);
        int          lat;
        logic [63:0] exp_res;
        exp_res = model(a, b, op, s);
        lat = 0;
        @(negedge clk);
        in_src0 = a; in_src1 = b; in_op = op; in_sign = s; in_valid = 1'b1; out_ready = 1'b0;
        check_val("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(negedge clk);
            scramble_inputs();
            @(posedge clk); #1;
            if (out_valid) lat = i;
            else check_val("res_hold_busy", {out_res1, out_res0}, last_res);
        end
        check_val("latency", 64'(lat), 64'(exp_latency(op)));
        check_val("res1", 64'(out_res1), 64'(exp_res[63:32]));
        check_val("res0", 64'(out_res0), 64'(exp_res[31:0]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            scramble_inputs();
            @(posedge clk); #1;
            check_val("done_valid_hold", 64'(out_valid), 64'd1);
            check_val("done_in_ready", 64'(in_ready), 64'd0);
            check_val("done_res_hold", {out_res1, out_res0}, exp_res);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("handshake_valid", 64'(out_valid), 64'd0);
        check_val("handshake_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        last_res = exp_res;
    endtask

    task automatic idle_ignore(input logic [1:0] op);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_src0 = $urandom; in_src1 = $urandom;
        @(posedge clk); #1;
        check_val("ignore_in_ready", 64'(in_ready), 64'd1);
        check_val("ignore_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic reset_mid_op();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        in_src0 = $urandom; in_src1 = $urandom | 32'd1; in_op = 2'd2; in_sign = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_res", {out_res1, out_res0}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_val("rst_no_stale_valid", 64'(seen), 64'd0);
        last_res = 64'd0;
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        logic        s;
        reset = 1'b1; in_src0 = '0; in_src1 = '0; in_op = '0; in_sign = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_in_ready", 64'(in_ready), 64'd1);
        check_val("reset_out_valid", 64'(out_valid), 64'd0);
        check_val("reset_res", {out_res1, out_res0}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        idle_ignore(2'd0);
        idle_ignore(2'd3);

        run_op(32'hFFFF_FFFE, 32'd3,        2'd1, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 32'd2,        2'd2, 1'b1, 0);
        run_op(32'd100,       32'd7,        2'd2, 1'b0, 0);
        run_op(32'h1234_5678, 32'd0,        2'd2, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 1'b1, 5);
        run_op(32'hF000_0001, 32'd0,        2'd2, 1'b1, 1);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 2'd2, 1'b0, 0);

        reset_mid_op();

        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            op = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
            s  = 1'($urandom);
            run_op(a, b, op, s, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
